sub_bytes_iter: RTL

Iterative forward SubBytes unit for the AES encryption datapath. It accepts one 128-bit state over a valid/ready handshake and applies the forward S-box to every byte, LANES bytes per cycle, using LANES shared `sub_box` instances. It then presents the substituted state over a second valid/ready handshake. It is the area-reduced encrypt-side counterpart of the decrypt-side byte-substitution stage, and sits between AddRoundKey and ShiftRows in the round loop.

---
 rtl/sub_bytes_iter.sv | 74 +++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES forward SubBytes, LANES bytes per cycle through shared S-boxes.
module sub_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out_byte = SBOX[{in_byte, 3'b000} +: 8];
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_out
);
    localparam int BEATS = 16 / LANES;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [0:127]  state_reg, next_reg;
    logic [7:0]    sb_in [LANES];
    logic [7:0]    sb_out [LANES];
    int            base;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sub_box u_box (.in_byte(sb_in[i]), .out_byte(sb_out[i]));
    end
    // The current beat's byte window goes through the S-boxes and is written back in place.
    always_comb begin
        base = int'(cnt) * LANES;
        next_reg = state_reg;
        for (int k = 0; k < LANES; k++) begin
            sb_in[k] = state_reg[8*(base+k) +: 8];
            next_reg[8*(base+k) +: 8] = sb_out[k];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            state_reg <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                state_reg <= data_in;
                cnt       <= '0;
                state     <= BUSY;
            end
        end else if (state == BUSY) begin
            state_reg <= next_reg;
            cnt       <= cnt == CW'(BEATS - 1) ? '0 : cnt + 1'b1;
            state     <= cnt == CW'(BEATS - 1) ? DONE : BUSY;
        end else if (out_ready) begin
            state <= IDLE;
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign data_out  = state_reg;
endmodule
